punc_mem_responder: RTL and testbench

- Word-addressed 16-bit memory responder serving the PUnC LC3 control/datapath as initiator.
- Accepts one read or write request at a time over a valid/ready handshake, waits a fixed, parameterised access latency, then returns a response that is held until the initiator accepts it.
- Sits between the PUnC core and its instruction/data storage, letting the control FSM be exercised against realistic multi-cycle memory.

---
 rtl/punc_mem_responder.sv | 132 +++++++++++++
 tb/tb_punc_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/punc_mem_responder.sv
// punc_mem_responder
// Word-addressed 16-bit memory with a fixed, parameterised access latency.
// It accepts one request at a time on a valid/ready handshake. After
// LATENCY cycles it returns a response, which it holds until the
// initiator accepts it. The PUnC control FSM uses it as a realistic
// multi-cycle memory.

module punc_mem_responder #(
    parameter int MEM_DEPTH = 128,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [16:0] DEPTH_LIM = 17'(MEM_DEPTH);
    localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          lat_we;
    logic [15:0]   lat_addr;
    logic [15:0]   lat_wdata;

    logic [15:0]   mem [MEM_DEPTH];

    logic          in_range;
    logic          access;
    logic          do_write;
    logic [AW-1:0] mem_idx;

    // Compare the full 16-bit address so that high addresses never wrap
    // onto a real location.
    assign in_range = ({1'b0, lat_addr} < DEPTH_LIM);
    assign access   = (state == WAIT) && (cnt == 4'd0);
    assign do_write = access && lat_we && in_range;
    assign mem_idx  = lat_addr[AW-1:0];

    // Storage array: commits a latched write on the cycle WAIT exits.
    // NOTE: the array has no reset branch. Resetting every word would
    // cost a large reset tree and would block RAM inference. An async
    // reset forces state out of WAIT, so a dropped write can never
    // commit.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[mem_idx] <= lat_wdata;
        end
    end

    // Control FSM: latches the request, counts latency, then presents and
    // holds the response with registered handshake outputs.
    // NOTE: every register below takes a non-blocking assignment. Other
    // blocks then see the values from before this edge, which is what
    // keeps simulation in step with the synthesised flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 16'h0000;
            lat_wdata <= 16'h0000;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= CNT_LOAD;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // The memory block performs the write on this
                        // same edge. Only read data is returned here.
                        if (in_range && !lat_we) begin
                            rsp_rdata <= mem[mem_idx];
                        end else begin
                            rsp_rdata <= 16'h0000;
                        end
                        rsp_err   <= !in_range;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    // The next request can only be taken from IDLE. That
                    // rules out accepting one in the same cycle as the
                    // response handshake.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_punc_mem_responder.sv
// tb_punc_mem_responder
// Drives a LATENCY=2 instance (index 0) and a LATENCY=1 instance (index 1)
// with directed requests. The expected response for each request is
// queued when the request is issued. A negedge monitor pops the queue
// and compares on every response handshake.

module tb_punc_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [15:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_rdata [2];
    logic        rsp_err   [2];

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;

    punc_mem_responder #(.MEM_DEPTH(128), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    punc_mem_responder #(.MEM_DEPTH(128), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Issue one request on instance k. Check the latency and handshake
    // timing, optionally hold backpressure, then acknowledge. On entry
    // we are just after a rising edge.
    task automatic issue(input int k, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rdata,
                         input logic exp_err, input int hold);
        int   lat;
        exp_t e;
        lat = (k == 0) ? 2 : 1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_valid[k] = 1'b1;
        check("req_ready_idle", req_ready[k], 1);
        @(posedge clk); #1;
        // Scramble the request inputs after acceptance. The response must
        // still reflect the original request.
        req_valid[k] = 1'b0;
        req_we[k]    = ~we;
        req_addr[k]  = ~addr;
        req_wdata[k] = ~wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        if (k == 0) q0.push_back(e); else q1.push_back(e);
        check("req_ready_wait", req_ready[k], 0);
        check("rsp_valid_accept", rsp_valid[k], 0);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            check("rsp_valid_latency", rsp_valid[k], (i == lat) ? 1 : 0);
        end
        for (int h = 0; h < hold; h++) begin
            req_valid[k] = 1'b1;
            @(posedge clk); #1;
            check("hold_rsp_valid", rsp_valid[k], 1);
            check("hold_req_ready", req_ready[k], 0);
            check("hold_rsp_rdata", rsp_rdata[k], exp_rdata);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
        req_valid[k] = 1'b0;
        check("ack_rsp_valid", rsp_valid[k], 0);
        check("ack_req_ready", req_ready[k], 1);
    endtask

    // Scoreboard monitor: the response is compared when it is handed over.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                if (rsp_valid[k] && rsp_ready[k]) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        check("rsp_unexpected", rsp_valid[k], 0);
                    end else begin
                        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
                        check("rsp_rdata", rsp_rdata[k], e.rdata);
                        check("rsp_err", rsp_err[k], e.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = 16'h0000;
            req_wdata[k] = 16'h0000;
            rsp_ready[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_req_ready", req_ready[k], 1);
            check("rst_rsp_valid", rsp_valid[k], 0);
            check("rst_rsp_rdata", rsp_rdata[k], 16'h0000);
            check("rst_rsp_err", rsp_err[k], 0);
        end
        rst = 1'b1;
        // rsp_ready asserted while no response is pending must do nothing.
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        check("idle_req_ready", req_ready[0], 1);
        check("idle_rsp_valid", rsp_valid[0], 0);

        // Write then read back.
        issue(0, 1'b1, 16'd5, 16'hBEEF, 16'h0000, 1'b0, 0);
        issue(0, 1'b0, 16'd5, 16'h0000, 16'hBEEF, 1'b0, 0);

        // Backpressure for 10 cycles, with a second request held during RESP.
        issue(0, 1'b0, 16'd5, 16'h0000, 16'hBEEF, 1'b0, 10);

        // Address boundaries.
        issue(0, 1'b1, 16'd0,    16'h0F0F, 16'h0000, 1'b0, 0);
        issue(0, 1'b1, 16'h007F, 16'hC3C3, 16'h0000, 1'b0, 0);
        issue(0, 1'b1, 16'h0080, 16'h1234, 16'h0000, 1'b1, 0);
        issue(0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 0);
        issue(0, 1'b0, 16'd0,    16'h0000, 16'h0F0F, 1'b0, 0);
        issue(0, 1'b0, 16'h007F, 16'h0000, 16'hC3C3, 1'b0, 0);

        // Reset while in WAIT drops a pending write.
        issue(0, 1'b1, 16'd7, 16'h5555, 16'h0000, 1'b0, 0);
        req_we[0]    = 1'b1;
        req_addr[0]  = 16'd7;
        req_wdata[0] = 16'hAAAA;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("midwait_accepted", req_ready[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midwait_rst_rsp_valid", rsp_valid[0], 0);
        check("midwait_rst_req_ready", req_ready[0], 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("after_rst_rsp_valid", rsp_valid[0], 0);
        issue(0, 1'b0, 16'd7, 16'h0000, 16'h5555, 1'b0, 0);

        // LATENCY=1 instance: one-cycle WAIT. Scrambled inputs after
        // acceptance must not leak into the response.
        issue(1, 1'b1, 16'd3,    16'h1357, 16'h0000, 1'b0, 0);
        issue(1, 1'b0, 16'd3,    16'h0000, 16'h1357, 1'b0, 0);
        issue(1, 1'b0, 16'h0080, 16'h0000, 16'h0000, 1'b1, 2);

        @(posedge clk); #1;
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
